// File: rtl/imem_pkg.sv
// Shared constants and boot image for the MIPS instruction store.
package imem_pkg;

  localparam int unsigned IMEM_AW    = 8;
  localparam int unsigned IMEM_DEPTH = 256;
  localparam int unsigned IMEM_DW    = 32;

  localparam logic [IMEM_DW-1:0] NOP = '0;

  // Boot program: a small ALU/memory/branch loop; every word past 11 is NOP.
  function automatic logic [IMEM_DW-1:0] boot_word(input int unsigned idx);
    logic [IMEM_DW-1:0] word;
    case (idx)
      0:       word = 32'h2008_0005; // addi $t0,$0,5
      1:       word = 32'h2009_000A; // addi $t1,$0,10
      2:       word = 32'h0109_5020; // add  $t2,$t0,$t1
      3:       word = 32'h0128_5822; // sub  $t3,$t1,$t0
      4:       word = 32'h0109_6024; // and  $t4,$t0,$t1
      5:       word = 32'h0109_6825; // or   $t5,$t0,$t1
      6:       word = 32'h0109_702A; // slt  $t6,$t0,$t1
      7:       word = 32'hAC0A_0000; // sw   $t2,0($0)
      8:       word = 32'h8C0F_0000; // lw   $t7,0($0)
      9:       word = 32'h114F_0001; // beq  $t2,$t7,+1
      10:      word = 32'h2108_0001; // addi $t0,$t0,1
      11:      word = 32'h0800_0000; // j    0
      default: word = NOP;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/instruction_memory.sv
// Read-only, word-addressed instruction store with combinational read.
// The boot image is present from power-up and reloaded on synchronous reset.
module instruction_memory
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = IMEM_DEPTH,
  parameter int unsigned WIDTH = IMEM_DW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [IMEM_AW-1:0] read_address,
  output logic [WIDTH-1:0]   instruction
);

  typedef logic [WIDTH-1:0] mem_t [DEPTH];

  function automatic mem_t boot_image();
    mem_t img;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      img[i] = WIDTH'(boot_word(i));
    end
    return img;
  endfunction

  // Declaration initialiser gives the time-zero image without an initial block.
  mem_t mem = boot_image();

  // Reload the whole image on a clean reset; X/Z on reset leaves the array alone.
  always_ff @(posedge clk) begin
    if (reset === 1'b1) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(boot_word(i));
      end
    end
  end

  // Unclocked read; a definite reset forces a NOP onto the fetch path.
  always_comb begin
    instruction = mem[read_address];
    if (reset === 1'b1) begin
      instruction = '0;
    end
  end

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory against an image-table model.
module tb_instruction_memory;

  logic        clk;
  logic        reset;
  logic [7:0]  read_address;
  logic [31:0] instruction;

  int tests_run;
  int tests_failed;

  // Program words from the boot listing; everything beyond index 11 is zero.
  logic [31:0] image [12] = '{
    32'h20080005, 32'h2009000A, 32'h01095020, 32'h01285822,
    32'h01096024, 32'h01096825, 32'h0109702A, 32'hAC0A0000,
    32'h8C0F0000, 32'h114F0001, 32'h21080001, 32'h08000000
  };

  instruction_memory #(.DEPTH(256), .WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .read_address (read_address),
    .instruction  (instruction)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model(input logic rst, input logic [7:0] addr);
    if (rst === 1'b1) return 32'h0;
    if (addr < 8'd12) return image[addr];
    return 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] expected);
    tests_run++;
    assert (instruction === expected)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h (addr %0d reset %b)",
             tag, instruction, expected, read_address, reset);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    read_address = 8'd0;

    // Power-up contents without any reset.
    #2 check("powerup_addr0", 32'h20080005);
    #20 read_address = 8'd1;
    #1 check("powerup_addr1", 32'h2009000A);
    #19 read_address = 8'd2;
    #1 check("powerup_addr2", 32'h01095020);

    // Full program sweep plus zero-filled tail.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      read_address = 8'(i);
      #1 check($sformatf("sweep_%0d", i), model(1'b0, read_address));
    end
    @(negedge clk); read_address = 8'd12;  #1 check("tail_12",  32'h0);
    @(negedge clk); read_address = 8'd128; #1 check("tail_128", 32'h0);
    @(negedge clk); read_address = 8'd255; #1 check("tail_255", 32'h0);

    // Held reset gates to NOP; release shows the word without a clock edge.
    @(negedge clk);
    read_address = 8'd3;
    reset        = 1'b1;
    #1 check("reset_gate", 32'h0);
    @(negedge clk);
    #1 check("reset_gate_held", 32'h0);
    #1 reset = 1'b0;
    #1 check("reset_release", 32'h01285822);

    // One-cycle reset mid-run leaves contents identical.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    read_address = 8'd0;  #1 check("reload_0",  32'h20080005);
    @(negedge clk); read_address = 8'd9;  #1 check("reload_9",  32'h114F0001);
    @(negedge clk); read_address = 8'd11; #1 check("reload_11", 32'h08000000);

    // Address changes between edges propagate immediately.
    @(negedge clk);
    read_address = 8'd7; #1 check("midcycle_7", 32'hAC0A0000);
    #1 read_address = 8'd8; #1 check("midcycle_8", 32'h8C0F0000);

    // Unknown reset for several cycles must not disturb the array.
    @(negedge clk);
    reset = 1'bx;
    repeat (4) @(negedge clk);
    reset        = 1'b0;
    read_address = 8'd10;
    #1 check("x_reset_10", 32'h21080001);

    // Randomised traffic with occasional reset pulses and mid-cycle address moves.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      read_address = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) read_address = 8'($urandom_range(0, 13));
      reset = ($urandom_range(0, 9) == 0);
      #1 check("random", model(reset, read_address));
      if ($urandom_range(0, 1) == 1) begin
        #1 read_address = 8'($urandom_range(0, 15));
        #1 check("random_mid", model(reset, read_address));
      end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      read_address = 8'(i);
      #1 check("final_sweep", model(1'b0, read_address));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
